saw_period_meter: RTL and testbench

SAW_PERIOD_METER -- requirements
Module: saw_period_meter

---
 rtl/saw_period_meter_if.sv | 14 +
 rtl/saw_period_meter.sv | 119 +++++++++++
 tb/tb_saw_period_meter.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/saw_period_meter_if.sv
// Sawtooth-in / tuning-word-out bundle for saw_period_meter.
// The master drives samples; the slave (meter) returns the measurement.
interface saw_period_meter_if #(
  parameter int SAW_W = 11
);
  logic [SAW_W-1:0] saw_in;
  logic [31:0]      tuning_word_out;
  logic             tw_valid;
  logic             busy;
  logic             no_signal;

  modport master (output saw_in, input tuning_word_out, tw_valid, busy, no_signal);
  modport slave  (input saw_in, output tuning_word_out, tw_valid, busy, no_signal);
endinterface

// File: rtl/saw_period_meter.sv
// Measures the period of a sawtooth between wraps and recovers the phase
// accumulator tuning word floor(2^ACC_W / period) with a bit-serial divider.
module saw_period_meter #(
  parameter int SAW_W = 11,
  parameter int ACC_W = 28,
  parameter int PER_W = 24
) (
  input  logic               clk,
  input  logic               rst,
  saw_period_meter_if.slave  io_meter
);
  typedef enum logic [1:0] {ARM = 2'd0, MEASURE = 2'd1, DIVIDE = 2'd2} state_t;

  localparam int              IW        = $clog2(ACC_W + 1);
  localparam logic [IW-1:0]   ITER_LAST = IW'(ACC_W);
  localparam logic [PER_W-1:0] PER_MAX  = '1;

  state_t             r_state, w_state_nxt;
  logic [SAW_W-1:0]   r_saw_prev, w_drop;
  logic               w_wrap, w_start, w_done, w_timeout;
  logic [PER_W-1:0]   r_per, r_div, r_rem, w_rem_sub, w_rem_nxt;
  logic [PER_W:0]     w_rem_sh;
  logic               w_qbit;
  logic [ACC_W:0]     r_dvd, w_quo;
  logic [IW-1:0]      r_iter;
  logic [31:0]        r_tw;
  logic               r_tw_vld, r_busy, r_no_sig;

  // A wrap is a drop of at least half scale; smaller drops are treated as noise.
  assign w_drop = r_saw_prev - io_meter.saw_in;
  assign w_wrap = (io_meter.saw_in < r_saw_prev) && w_drop[SAW_W-1];

  assign w_rem_sh  = {r_rem, r_dvd[ACC_W]};
  assign w_qbit    = (w_rem_sh >= {1'b0, r_div});
  assign w_rem_sub = w_rem_sh[PER_W-1:0] - r_div;
  assign w_rem_nxt = w_qbit ? w_rem_sub : w_rem_sh[PER_W-1:0];
  assign w_quo     = {r_dvd[ACC_W-1:0], w_qbit};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ARM;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_done      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ARM: begin
        if (w_wrap) w_state_nxt = MEASURE;
      end
      MEASURE: begin
        if (w_wrap) begin
          w_state_nxt = DIVIDE;
          w_start     = 1'b1;
        end else if (r_per == PER_MAX) begin
          w_state_nxt = ARM;
          w_timeout   = 1'b1;
        end
      end
      DIVIDE: begin
        if (r_iter == ITER_LAST) begin
          w_state_nxt = MEASURE;
          w_done      = 1'b1;
        end
      end
      default: w_state_nxt = ARM;
    endcase
  end

  // Period counter: restarts on every wrap, saturates instead of rolling over.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_saw_prev <= '0;
      r_per      <= '0;
    end else begin
      r_saw_prev <= io_meter.saw_in;
      if (w_wrap)                             r_per <= {{(PER_W-1){1'b0}}, 1'b1};
      else if (r_state == ARM || w_timeout)   r_per <= '0;
      else if (r_per != PER_MAX)              r_per <= r_per + 1'b1;
    end
  end

  // Restoring divider: r_dvd shifts the dividend out and the quotient in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div    <= '0;
      r_rem    <= '0;
      r_dvd    <= '0;
      r_iter   <= '0;
      r_tw     <= '0;
      r_tw_vld <= 1'b0;
      r_busy   <= 1'b0;
      r_no_sig <= 1'b1;
    end else begin
      if (w_start) begin
        r_div  <= r_per;
        r_rem  <= '0;
        r_dvd  <= {1'b1, {ACC_W{1'b0}}};
        r_iter <= '0;
      end else if (r_state == DIVIDE) begin
        r_rem  <= w_rem_nxt;
        r_dvd  <= w_quo;
        r_iter <= r_iter + 1'b1;
      end
      if (w_done) r_tw <= {{(31-ACC_W){1'b0}}, w_quo};
      r_tw_vld <= w_done;
      r_busy   <= (w_state_nxt == DIVIDE);
      if (w_done)         r_no_sig <= 1'b0;
      else if (w_timeout) r_no_sig <= 1'b1;
    end
  end

  assign io_meter.tuning_word_out = r_tw;
  assign io_meter.tw_valid        = r_tw_vld;
  assign io_meter.busy            = r_busy;
  assign io_meter.no_signal       = r_no_sig;
endmodule

// File: tb/tb_saw_period_meter.sv
// Scoreboard bench for saw_period_meter: a phase-accumulator driver queues the
// expected tuning words; a negedge monitor pops and compares them.
module tb_saw_period_meter;
  localparam int SAW_W = 11;
  localparam int ACC_W = 28;
  localparam int PER_W = 10;   // narrow counter keeps the timeout reachable

  typedef struct {
    logic [31:0] tw;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  logic [27:0] acc     = '0;
  bit          m_armed = 1'b0;
  int          m_last  = 0;
  int          m_div_w = -1000;

  saw_period_meter_if #(.SAW_W(SAW_W)) bus ();

  saw_period_meter #(.SAW_W(SAW_W), .ACC_W(ACC_W), .PER_W(PER_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .io_meter (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference wrap handling: first wrap arms, later wraps yield a result
  // unless the divider is still busy with the previous one.
  task automatic model_wrap(input int x);
    longint q;
    if (!m_armed) begin
      m_armed = 1'b1;
    end else if (x > m_div_w + 29) begin
      q = (longint'(1) << ACC_W) / longint'(x - m_last);
      sb.push_back('{tw: 32'(q), cyc: x + 29});
      m_div_w = x;
    end
    m_last = x;
  endtask

  task automatic drive(input logic [SAW_W-1:0] v, input bit is_wrap);
    bus.saw_in = v;
    @(posedge clk);
    #1;
    if (is_wrap) model_wrap(cyc);
  endtask

  task automatic acc_step(input logic [27:0] tw);
    logic [28:0] s;
    s   = {1'b0, acc} + {1'b0, tw};
    acc = s[27:0];
    drive(acc[27:17], s[28]);
  endtask

  task automatic run_acc(input logic [27:0] tw, input int n);
    for (int i = 0; i < n; i++) acc_step(tw);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    chk("busy", {31'b0, bus.busy}, {31'b0, (cyc >= m_div_w) && (cyc < m_div_w + 29)});
    if (sb.size() > 0 && cyc > sb[0].cyc) begin
      n_checks++;
      n_errors++;
      $display("FAIL tw_missing: actual none, required %0d at cycle %0d", sb[0].tw, sb[0].cyc);
      void'(sb.pop_front());
    end
    if (bus.tw_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL tw_unexpected: actual %0d at cycle %0d, required no pulse",
                 bus.tuning_word_out, cyc);
      end else begin
        e = sb.pop_front();
        chk("tw_value", bus.tuning_word_out, e.tw);
        chk("tw_cycle", cyc, e.cyc);
        chk("no_signal_at_valid", {31'b0, bus.no_signal}, 32'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    rst        = 1'b0;
    bus.saw_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tw",        bus.tuning_word_out, 32'd0);
    chk("rst_tw_valid",  {31'b0, bus.tw_valid}, 32'd0);
    chk("rst_busy",      {31'b0, bus.busy}, 32'd0);
    chk("rst_no_signal", {31'b0, bus.no_signal}, 32'd1);
    rst = 1'b1;

    // 500->300 is noise; 2000->10 is the arming wrap
    drive(11'd500, 1'b0);
    drive(11'd300, 1'b0);
    drive(11'd2000, 1'b0);
    drive(11'd10, 1'b1);
    chk("no_signal_armed", {31'b0, bus.no_signal}, 32'd1);

    acc = {11'd10, 17'd0};
    run_acc(28'd1 << 20, 800);
    chk("tw_2p20_hold", bus.tuning_word_out, 32'd1048576);
    chk("no_signal_cleared", {31'b0, bus.no_signal}, 32'd0);

    run_acc(28'd3000000, 600);
    run_acc(28'd1 << 24, 200);

    k = 0;
    while (cyc != m_div_w + 10 && k < 200) begin
      acc_step(28'd1 << 24);
      k++;
    end
    chk("divide_reached", cyc, m_div_w + 10);
    chk("busy_mid_divide", {31'b0, bus.busy}, 32'd1);

    rst = 1'b0;
    sb.delete();
    m_armed = 1'b0;
    m_div_w = -1000;
    #1;
    chk("abort_tw",        bus.tuning_word_out, 32'd0);
    chk("abort_tw_valid",  {31'b0, bus.tw_valid}, 32'd0);
    chk("abort_busy",      {31'b0, bus.busy}, 32'd0);
    chk("abort_no_signal", {31'b0, bus.no_signal}, 32'd1);
    repeat (3) drive(11'd0, 1'b0);
    rst = 1'b1;
    acc = '0;
    run_acc(28'd1 << 20, 600);
    chk("tw_after_abort", bus.tuning_word_out, 32'd1048576);

    // Constant input: no wraps, counter saturates and times out
    k = 0;
    while (cyc < m_last + 1022 && k < 2000) begin
      drive(11'd700, 1'b0);
      k++;
    end
    chk("no_signal_pre_timeout", {31'b0, bus.no_signal}, 32'd0);
    drive(11'd700, 1'b0);
    chk("no_signal_timeout", {31'b0, bus.no_signal}, 32'd1);
    chk("tw_kept_timeout", bus.tuning_word_out, 32'd1048576);
    repeat (40) drive(11'd700, 1'b0);
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
